// File: rtl/counter_pkg.sv
// Shared types and defaults for the modulo counter and the display/timer blocks that reuse it.
package counter_pkg;

  typedef enum logic {
    WRAP = 1'b0,
    SAT  = 1'b1
  } mode_t;

  localparam int unsigned DEFAULT_WIDTH     = 4;
  localparam int unsigned DEFAULT_TICK_LOG2 = 23;

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler producing a one-cycle clock-enable tick every 2^TICK_LOG2 cycles.
module tick_gen #(
  parameter int unsigned TICK_LOG2 = 23
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  output logic tick_o
);

  // Keep at least one flop so the zero-length case still elaborates; it is trimmed away.
  localparam int unsigned PW = (TICK_LOG2 == 0) ? 1 : TICK_LOG2;

  logic [PW-1:0] presc_q, presc_d;

  always_comb begin
    presc_d = presc_q + PW'(1);
    if (clr_i) begin
      presc_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  assign tick_o = (TICK_LOG2 == 0) ? 1'b1 : (&presc_q);

endmodule

// File: rtl/mod_counter.sv
// Up/down modulo counter with load, clear, wrap/saturate modes and a built-in tick prescaler.
module mod_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter int unsigned MODULUS   = 16,
  parameter int unsigned TICK_LOG2 = DEFAULT_TICK_LOG2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             up_i,
  input  mode_t            mode_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic [WIDTH-1:0] count_o,
  output logic             tc_o,
  output logic             zero_o
);

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MODULUS - 1);

  logic             tick;
  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;

  tick_gen #(
    .TICK_LOG2(TICK_LOG2)
  ) u_tick_gen (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .clr_i (clr_i),
    .tick_o(tick)
  );

  // Boundary is tested before the add/subtract so the count never leaves 0..MODULUS-1.
  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    if (clr_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d = (load_val_i > MaxVal) ? MaxVal : load_val_i;
    end else if (tick && en_i) begin
      if (up_i) begin
        if (count_q == MaxVal) begin
          tc_d = 1'b1;
          if (mode_i == WRAP) begin
            count_d = '0;
          end
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end else begin
        if (count_q == '0) begin
          tc_d = 1'b1;
          if (mode_i == WRAP) begin
            count_d = MaxVal;
          end
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
    end
  end

  assign count_o = count_q;
  assign tc_o    = tc_q;
  assign zero_o  = (count_q == '0);

endmodule
